// File: rtl/data_mem_ctrl.sv
// Data memory for the RV32I MEM stage: byte/half/word loads and stores, MMIO output registers,
// misalignment detection and a multi-cycle stall handshake toward the pipeline.
module data_mem_ctrl #(
    parameter int          ADDR_BITS = 10,
    parameter int          NUM_IO    = 2,
    parameter int          IO_WIDTH  = 8,
    parameter logic [31:0] MMIO_BASE = 32'h2000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  write_data,
    input  logic                         memwrite,
    input  logic                         memread,
    input  logic [3:0]                   sign_mask,
    output logic [31:0]                  read_data,
    output logic                         clk_stall,
    output logic                         misalign_err,
    output logic [NUM_IO*IO_WIDTH-1:0]   io_out
);

    localparam int IO_IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    function automatic size_t access_size(input logic [2:0] m);
        casez (m)
            3'b1??:  return SZ_WORD;
            3'b01?:  return SZ_HALF;
            default: return SZ_BYTE;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] lane, input size_t sz);
        if (sz == SZ_WORD) return lane != 2'b00;
        if (sz == SZ_HALF) return lane[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input size_t sz, input logic sext);
        logic signed [15:0] half_v;
        logic signed [7:0]  byte_v;
        half_v = lane[1] ? word[31:16] : word[15:0];
        byte_v = word[{lane, 3'b000} +: 8];
        if (sz == SZ_WORD) return word;
        if (sz == SZ_HALF) return sext ? 32'(half_v) : 32'($unsigned(half_v));
        return sext ? 32'(byte_v) : 32'($unsigned(byte_v));
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] lane, input size_t sz);
        logic [31:0] merged;
        merged = word;
        if (sz == SZ_WORD)      merged = data;
        else if (sz == SZ_HALF) merged[{lane[1], 4'b0000} +: 16] = data[15:0];
        else                    merged[{lane, 3'b000} +: 8] = data[7:0];
        return merged;
    endfunction

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, word_q;
    logic [3:0]           mask_q, mask_d;
    logic                 store_q, store_d, mis_q, mis_d, err_q, err_d;
    logic [IO_WIDTH-1:0]  io_q [NUM_IO];
    logic [IO_WIDTH-1:0]  io_d [NUM_IO];
    logic [31:0]          mem [2**ADDR_BITS];
    logic                 mem_we, in_mmio;
    logic [ADDR_BITS-1:0] mem_idx;
    logic [31:0]          io_off;
    logic [IO_IDX_W-1:0]  io_idx;

    // Upper address bits are ignored by the array, so anything outside the MMIO window aliases.
    assign mem_idx = addr_q[ADDR_BITS+1:2];
    assign io_off  = addr_q - MMIO_BASE;
    assign in_mmio = (addr_q >= MMIO_BASE) && (io_off < 32'(4 * NUM_IO));
    assign io_idx  = io_off[IO_IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        store_d = store_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        io_d    = io_q;
        unique case (state_q)
            IDLE: begin
                if (memread || memwrite) begin
                    addr_d  = addr;
                    wdata_d = write_data;
                    mask_d  = sign_mask;
                    store_d = memwrite;
                    mis_d   = is_misaligned(addr[1:0], access_size(sign_mask[2:0]));
                    state_d = FETCH;
                end
            end
            FETCH: begin
                err_d   = mis_q;
                state_d = UPDATE;
            end
            UPDATE: begin
                state_d = DONE;
                if (store_q) begin
                    if (!mis_q) begin
                        if (in_mmio) io_d[io_idx] = wdata_q[IO_WIDTH-1:0];
                        else         mem_we = 1'b1;
                    end
                end else if (mis_q) begin
                    rdata_d = '0;
                end else if (in_mmio) begin
                    rdata_d = 32'(io_q[io_idx]);
                end else begin
                    rdata_d = load_extract(word_q, addr_q[1:0], access_size(mask_q[2:0]), mask_q[3]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= '0;
            for (int k = 0; k < NUM_IO; k++) io_q[k] <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            io_q    <= io_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        mask_q  <= mask_d;
        store_q <= store_d;
        mis_q   <= mis_d;
    end

    // Array is never reset; a reset landing in UPDATE must still drop the pending store.
    always_ff @(posedge clk) begin
        if (state_q == FETCH) word_q <= mem[mem_idx];
        if (mem_we && !reset) mem[mem_idx] <= store_merge(word_q, wdata_q, addr_q[1:0], access_size(mask_q[2:0]));
    end

    // Stall covers the request cycle plus FETCH and UPDATE, so the core sees three stalled cycles.
    assign clk_stall    = (state_q == IDLE && (memread || memwrite)) || state_q == FETCH || state_q == UPDATE;
    assign read_data    = rdata_q;
    assign misalign_err = err_q;

    always_comb begin
        io_out = '0;
        for (int k = 0; k < NUM_IO; k++) io_out[k*IO_WIDTH +: IO_WIDTH] = io_q[k];
    end

endmodule
